rs485_poll_scheduler: RTL and testbench
=======================================

# rs485_poll_scheduler

Round-robin poll sequencer for the M16 orbital frame's RS485 sensor channels. Each poll round starts on `poll_start`. The block visits every enabled channel in turn and, for each one:
- drives the transceiver direction lines (`UART_dTX*`, `UART_dRX*`),
- launches the request through that channel's UART TX engine,
- opens the receive window and counts response bytes until a full frame arrives or a silence timeout expires.

It sits between the frame timing logic and the per-channel UART TX/RX engines. It also supplies the channel/byte selectors that steer received bytes into the frame buffer.

## Interface
Parameters:
- `NCH`, 5: number of channels (1..8)
- `BYTES`, 20: response length in bytes
- `GUARD`, 16: turnaround cycles between TX end and receiver enable
- `TIMEOUT`, 8000: max `clk80MHz` cycles of silence allowed in the RX window (≈100 µs)

Ports:
- `clk80MHz`, in, 1: sole clock
- `rst`, in, 1: asynchronous active-low reset
- `poll_start`, in, 1: one-cycle strobe that starts a round; ignored while `busy`=1
- `ch_en`, in, NCH: channel enable mask, sampled on the accepted `poll_start`
- `tx_busy`, in, NCH: per-channel UART TX engine busy
- `rx_valid`, in, NCH: per-channel received-byte strobe (one cycle per byte)
- `tx_start`, out, NCH: one-hot, one-cycle request launch
- `UART_dTX`, out, NCH: driver enable, active high
- `UART_dRX`, out, NCH: receiver disable, active high; 0 = listening
- `rx_sel`, out, 3: index of the channel being served
- `byte_idx`, out, 5: index of the next expected byte (0..BYTES-1)
- `ch_ok`, out, NCH: channel returned `BYTES` bytes this round
- `ch_timeout`, out, NCH: channel timed out this round
- `busy`, out, 1: round in progress
- `round_done`, out, 1: one-cycle strobe at the end of a round

## Operation
- States: IDLE → SEL → TX_START → TX_WAIT → TURN → RX → SEL … → DONE → IDLE.
- **IDLE**
  - On an accepted `poll_start`, latch `ch_en` into `mask`.
  - Clear `ch_ok`/`ch_timeout`, set `busy`=1, set `rx_sel`=0, go to SEL.
- **SEL**
  - If `mask[rx_sel]`=1, go to TX_START.
  - Otherwise increment `rx_sel`.
  - After index NCH-1, go to DONE.
  - Each SEL visit takes one cycle.
- **TX_START**: assert `tx_start[rx_sel]` and `UART_dTX[rx_sel]` for 1 cycle.
- **TX_WAIT**
  - Hold `UART_dTX[rx_sel]`=1.
  - `tx_busy` is ignored in the first cycle.
  - Exit to TURN on the first later cycle with `tx_busy[rx_sel]`=0.
- **TURN**: `UART_dTX`=0 and `UART_dRX`=1 for exactly `GUARD` cycles, then go to RX.
- **RX**
  - `UART_dRX[rx_sel]`=0.
  - Each `rx_valid[rx_sel]` increments `byte_idx` and clears the silence counter.
  - `rx_valid` on any other channel is ignored.
  - When `byte_idx` reaches `BYTES`: set `ch_ok[rx_sel]`.
  - When the silence counter reaches `TIMEOUT`: set `ch_timeout[rx_sel]`.
  - In either case: set `UART_dRX`=1, clear `byte_idx`, increment `rx_sel`, go to SEL.
- **DONE**: pulse `round_done` for 1 cycle, clear `busy`, go to IDLE.
- Simultaneous final byte and timeout in the same cycle: the byte wins (`ch_ok`=1, `ch_timeout`=0).
- A mask with all channels disabled completes the round with no line activity.
- Counter widths:
  - silence counter: clog2(TIMEOUT+1)
  - `byte_idx`: 5 bits, saturating is never required because `BYTES`≤31
- Asserting `rst` mid-round aborts immediately. All lines return to reset values; no `round_done` is issued.

## Timing
- Reset values:
  - `tx_start`=0, `UART_dTX`=0, `UART_dRX`=all 1
  - `rx_sel`=0, `byte_idx`=0
  - `ch_ok`=0, `ch_timeout`=0
  - `busy`=0, `round_done`=0
- All outputs are registered.
- `poll_start` → `busy`=1: 1 cycle.
- Accepted `poll_start` → first `tx_start`: 3 cycles when channel 0 is enabled.
- `tx_busy` falling edge → `UART_dTX` low: 1 cycle.
- `UART_dTX` low → `UART_dRX` low: `GUARD` cycles.
- Last byte → `UART_dRX` high: 1 cycle.
- At most one channel has `UART_dTX` or `UART_dRX`=0 active at any time.
- Status bits hold until the next accepted `poll_start`.

## Configuration
- `POLL_RETRY_EN`: when defined, a channel's first timeout in a round causes one re-poll of the same channel: TX_START again, `byte_idx` cleared. `ch_timeout` is set only if the retry also times out.
- Without the macro, a timeout moves straight to the next channel.

## Test plan
- All 5 channels enabled, each responds with 20 bytes (first byte = round counter, then 10,20…190) → `ch_ok`=5'h1F, `ch_timeout`=0, one `round_done`, `tx_start` pulses in channel order 0..4.
- `ch_en`=5'b10100 → `tx_start` only on channels 2 and 4; `ch_ok`=5'b10100; channels 0, 1 and 3 keep `UART_dRX`=1 throughout.
- Channel 3 sends 12 bytes then goes silent → after 8000 silent cycles `ch_timeout[3]`=1, `ch_ok[3]`=0; channel 4 is still polled.
- Bytes injected on channel 1 `rx_valid` while channel 0 is being served → ignored; channel 0 `byte_idx` is unaffected.
- Reset asserted during channel 2 RX → `UART_dRX`=5'h1F, `busy`=0 asynchronously; a new `poll_start` restarts from channel 0.
- With `POLL_RETRY_EN`, channel 1 is silent on the first attempt and answers the retry → two `tx_start[1]` pulses, `ch_ok[1]`=1, `ch_timeout[1]`=0.

Source files
------------

// File: rtl/rs485_poll_scheduler.sv
// Round-robin RS485 poll sequencer: per-channel TX launch, bus turnaround and RX byte window.
// Optional build macro POLL_RETRY_EN: a channel's first timeout in a round triggers one re-poll.
module rs485_poll_scheduler #(
    parameter int unsigned NCH     = 5,
    parameter int unsigned BYTES   = 20,
    parameter int unsigned GUARD   = 16,
    parameter int unsigned TIMEOUT = 8000
) (
    input  logic           clk80MHz,
    input  logic           rst,
    input  logic           poll_start,
    input  logic [NCH-1:0] ch_en,
    input  logic [NCH-1:0] tx_busy,
    input  logic [NCH-1:0] rx_valid,
    output logic [NCH-1:0] tx_start,
    output logic [NCH-1:0] UART_dTX,
    output logic [NCH-1:0] UART_dRX,
    output logic [2:0]     rx_sel,
    output logic [4:0]     byte_idx,
    output logic [NCH-1:0] ch_ok,
    output logic [NCH-1:0] ch_timeout,
    output logic           busy,
    output logic           round_done
);
    localparam int unsigned SW = $clog2(TIMEOUT + 1);
    localparam int unsigned GW = (GUARD > 1) ? $clog2(GUARD) : 1;

    localparam logic [SW-1:0] SilLast   = SW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GuardLast = GW'(GUARD - 1);
    localparam logic [4:0]    ByteLast  = 5'(BYTES - 1);
    localparam logic [3:0]    SelLast   = 4'(NCH - 1);
    localparam logic [3:0]    SelEnd    = 4'(NCH);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StSel     = 3'd1;
    localparam logic [2:0] StTxStart = 3'd2;
    localparam logic [2:0] StTxWait  = 3'd3;
    localparam logic [2:0] StTurn    = 3'd4;
    localparam logic [2:0] StRx      = 3'd5;
    localparam logic [2:0] StDone    = 3'd6;

    logic [2:0]     state_q, state_d;
    // One bit wider than rx_sel so that "past the last channel" is representable for NCH=8.
    logic [3:0]     sel_q, sel_d;
    logic [7:0]     mask_q, mask_d;
    logic [4:0]     byte_q, byte_d;
    logic [SW-1:0]  sil_q, sil_d;
    logic [GW-1:0]  cnt_q, cnt_d;
    logic [NCH-1:0] ok_q, ok_d;
    logic [NCH-1:0] to_q, to_d;
`ifdef POLL_RETRY_EN
    logic           retry_q, retry_d;
`endif

    logic [7:0] busy8, valid8, oh_q8, oh_d8;

    assign busy8  = 8'(tx_busy);
    assign valid8 = 8'(rx_valid);
    assign oh_q8  = 8'd1 << sel_q;
    assign oh_d8  = 8'd1 << sel_d;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        mask_d  = mask_q;
        byte_d  = byte_q;
        sil_d   = sil_q;
        cnt_d   = cnt_q;
        ok_d    = ok_q;
        to_d    = to_q;
`ifdef POLL_RETRY_EN
        retry_d = retry_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (poll_start) begin
                    mask_d  = 8'(ch_en);
                    ok_d    = '0;
                    to_d    = '0;
                    sel_d   = '0;
`ifdef POLL_RETRY_EN
                    retry_d = 1'b0;
`endif
                    state_d = StSel;
                end
            end
            StSel: begin
                if (sel_q >= SelEnd) begin
                    state_d = StDone;
                end else if (mask_q[sel_q[2:0]]) begin
                    state_d = StTxStart;
                end else if (sel_q == SelLast) begin
                    state_d = StDone;
                end else begin
                    sel_d = sel_q + 4'd1;
                end
            end
            StTxStart: begin
                cnt_d   = '0;
                byte_d  = '0;
                state_d = StTxWait;
            end
            StTxWait: begin
                // The UART engine only reports busy a cycle after the launch, so skip one cycle.
                if (cnt_q == '0) begin
                    cnt_d = GW'(1);
                end else if (!busy8[sel_q[2:0]]) begin
                    cnt_d   = '0;
                    state_d = StTurn;
                end
            end
            StTurn: begin
                if (cnt_q == GuardLast) begin
                    sil_d   = '0;
                    state_d = StRx;
                end else begin
                    cnt_d = cnt_q + GW'(1);
                end
            end
            StRx: begin
                // A byte clears the silence count first, so a last byte beats a same-cycle timeout.
                if (valid8[sel_q[2:0]]) begin
                    sil_d  = '0;
                    byte_d = byte_q + 5'd1;
                    if (byte_q == ByteLast) begin
                        ok_d    = ok_q | oh_q8[NCH-1:0];
                        byte_d  = '0;
                        sel_d   = sel_q + 4'd1;
`ifdef POLL_RETRY_EN
                        retry_d = 1'b0;
`endif
                        state_d = StSel;
                    end
                end else if (sil_q == SilLast) begin
                    byte_d = '0;
`ifdef POLL_RETRY_EN
                    if (!retry_q) begin
                        retry_d = 1'b1;
                        state_d = StTxStart;
                    end else begin
                        retry_d = 1'b0;
                        to_d    = to_q | oh_q8[NCH-1:0];
                        sel_d   = sel_q + 4'd1;
                        state_d = StSel;
                    end
`else
                    to_d    = to_q | oh_q8[NCH-1:0];
                    sel_d   = sel_q + 4'd1;
                    state_d = StSel;
`endif
                end else begin
                    sil_d = sil_q + SW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk80MHz or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            sel_q      <= '0;
            mask_q     <= '0;
            byte_q     <= '0;
            sil_q      <= '0;
            cnt_q      <= '0;
            ok_q       <= '0;
            to_q       <= '0;
`ifdef POLL_RETRY_EN
            retry_q    <= 1'b0;
`endif
            tx_start   <= '0;
            UART_dTX   <= '0;
            UART_dRX   <= '1;
            busy       <= 1'b0;
            round_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            mask_q     <= mask_d;
            byte_q     <= byte_d;
            sil_q      <= sil_d;
            cnt_q      <= cnt_d;
            ok_q       <= ok_d;
            to_q       <= to_d;
`ifdef POLL_RETRY_EN
            retry_q    <= retry_d;
`endif
            // Driver is enabled a cycle ahead of the launch strobe so the line is settled.
            tx_start   <= (state_q == StTxStart) ? oh_q8[NCH-1:0] : '0;
            UART_dTX   <= (state_d == StTxStart || state_d == StTxWait) ? oh_d8[NCH-1:0] : '0;
            UART_dRX   <= (state_d == StRx) ? ~oh_d8[NCH-1:0] : '1;
            busy       <= (state_d != StIdle);
            round_done <= (state_d == StDone);
        end
    end

    assign rx_sel     = sel_q[2:0];
    assign byte_idx   = byte_q;
    assign ch_ok      = ok_q;
    assign ch_timeout = to_q;

endmodule

// File: tb/tb_rs485_poll_scheduler.sv
// Scoreboard bench for rs485_poll_scheduler: stimulus queues expected launches and round status,
// a negedge monitor pops and compares; a responder process models the channel UARTs and slaves.
module tb_rs485_poll_scheduler;
    localparam int unsigned NCH     = 5;
    localparam int unsigned BYTES   = 20;
    localparam int unsigned GUARD   = 16;
    localparam int unsigned TIMEOUT = 8000;

    logic           clk80MHz = 1'b0;
    logic           rst = 1'b0;
    logic           poll_start = 1'b0;
    logic [NCH-1:0] ch_en = '0;
    logic [NCH-1:0] tx_busy = '0;
    logic [NCH-1:0] rx_valid = '0;
    logic [NCH-1:0] tx_start, UART_dTX, UART_dRX, ch_ok, ch_timeout;
    logic [2:0]     rx_sel;
    logic [4:0]     byte_idx;
    logic           busy, round_done;

    rs485_poll_scheduler #(
        .NCH(NCH), .BYTES(BYTES), .GUARD(GUARD), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk80MHz   (clk80MHz),
        .rst        (rst),
        .poll_start (poll_start),
        .ch_en      (ch_en),
        .tx_busy    (tx_busy),
        .rx_valid   (rx_valid),
        .tx_start   (tx_start),
        .UART_dTX   (UART_dTX),
        .UART_dRX   (UART_dRX),
        .rx_sel     (rx_sel),
        .byte_idx   (byte_idx),
        .ch_ok      (ch_ok),
        .ch_timeout (ch_timeout),
        .busy       (busy),
        .round_done (round_done)
    );

    always #5 clk80MHz = ~clk80MHz;

    typedef struct packed {
        logic       kind;  // 0: tx_start one-hot, 1: round status {ch_timeout, ch_ok}
        logic [9:0] val;
    } exp_t;

    exp_t           exp_q[$];
    int             total = 0;
    int             bad = 0;
    int             multi_viol = 0;
    int             quiet_viol = 0;
    logic [NCH-1:0] quiet_mask = '0;
    int             nbytes[NCH];
    bit             silent_first[NCH];
    int             attempt[NCH];
    int             noise_ch = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input logic kind, input logic [9:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic kind, input logic [9:0] val, input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: unexpected event kind=%0d val=0x%0h, want none", name, kind, val);
        end else begin
            e = exp_q.pop_front();
            check(name, {21'd0, kind, val}, {21'd0, e.kind, e.val});
        end
    endtask

    // Monitor: compares every launch and every round end against the scoreboard queue.
    always @(negedge clk80MHz) begin
        if (rst) begin
            if ($countones(UART_dTX | ~UART_dRX) > 1) multi_viol++;
            if (((UART_dTX | ~UART_dRX) & quiet_mask) != '0) quiet_viol++;
            if (tx_start != '0) pop_check(1'b0, 10'(tx_start), "tx_start order");
            if (round_done) pop_check(1'b1, {ch_timeout, ch_ok}, "round status");
        end
    end

    // Channel model: TX engine busy for 10 cycles, then the slave answers once the receiver opens.
    task automatic serve(input int c);
        int k;
        int n;
        attempt[c]++;
        tx_busy[c] = 1'b1;
        repeat (10) @(posedge clk80MHz);
        #1;
        check("dTX held during TX_WAIT", 32'(UART_dTX[c]), 1);
        tx_busy[c] = 1'b0;
        @(posedge clk80MHz); #1;
        check("dTX low 1 cycle after tx_busy", 32'(UART_dTX[c]), 0);
        k = 0;
        while (UART_dRX[c] && k < 100) begin
            @(posedge clk80MHz); #1;
            k++;
        end
        check("turnaround cycles", k, GUARD);
        n = (silent_first[c] && attempt[c] == 1) ? 0 : nbytes[c];
        for (int i = 0; i < n; i++) begin
            rx_valid[c] = 1'b1;
            @(posedge clk80MHz); #1;
            rx_valid[c] = 1'b0;
            if (i == n - 1 && n == BYTES) check("dRX high after last byte", 32'(UART_dRX[c]), 1);
            if (noise_ch >= 0 && c == 0 && i < n - 1) begin
                rx_valid[noise_ch] = 1'b1;
                @(posedge clk80MHz); #1;
                rx_valid[noise_ch] = 1'b0;
                if (i == 4) check("byte_idx ignores foreign rx_valid", byte_idx, 5);
            end else begin
                @(posedge clk80MHz); #1;
            end
        end
    endtask

    initial begin : responder
        forever begin
            @(posedge clk80MHz); #1;
            if (rst && tx_start != '0) begin
                for (int i = 0; i < NCH; i++) begin
                    if (tx_start[i]) serve(i);
                end
            end
        end
    end

    task automatic start_round(input logic [NCH-1:0] mask);
        for (int i = 0; i < NCH; i++) attempt[i] = 0;
        @(posedge clk80MHz); #1;
        poll_start = 1'b1;
        ch_en      = mask;
        @(posedge clk80MHz); #1;
        poll_start = 1'b0;
        check("busy 1 cycle after poll_start", 32'(busy), 1);
        check("ch_ok cleared on start", 32'(ch_ok), 0);
        check("ch_timeout cleared on start", 32'(ch_timeout), 0);
    endtask

    task automatic run_round(input logic [NCH-1:0] mask, input logic [NCH-1:0] exp_ok,
                             input logic [NCH-1:0] exp_to, input logic [NCH-1:0] twice);
        int n;
        for (int i = 0; i < NCH; i++) begin
            if (mask[i]) push_exp(1'b0, 10'(1 << i));
            if (mask[i] && twice[i]) push_exp(1'b0, 10'(1 << i));
        end
        push_exp(1'b1, {exp_to, exp_ok});
        start_round(mask);
        if (mask[0]) begin
            @(posedge clk80MHz); #1;
            check("no tx_start 2 cycles after start", 32'(tx_start), 0);
            @(posedge clk80MHz); #1;
            check("tx_start[0] 3 cycles after start", 32'(tx_start), 1);
        end
        n = 0;
        while (!round_done && n < 40000) begin
            @(posedge clk80MHz); #1;
            n++;
        end
        check("round_done seen", 32'(round_done), 1);
        @(posedge clk80MHz); #1;
        check("busy low after round", 32'(busy), 0);
        check("scoreboard drained", exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1);
    end

    initial begin : stim
        int n;
        for (int i = 0; i < NCH; i++) begin
            nbytes[i]       = BYTES;
            silent_first[i] = 1'b0;
            attempt[i]      = 0;
        end
        repeat (3) @(posedge clk80MHz);
        #1;
        check("reset UART_dRX (in reset)", 32'(UART_dRX), 32'h1F);
        rst = 1'b1;
        @(posedge clk80MHz); #1;
        check("reset tx_start", 32'(tx_start), 0);
        check("reset UART_dTX", 32'(UART_dTX), 0);
        check("reset UART_dRX", 32'(UART_dRX), 32'h1F);
        check("reset rx_sel/byte_idx", {24'd0, rx_sel, byte_idx}, 0);
        check("reset ch_ok/ch_timeout", {22'd0, ch_timeout, ch_ok}, 0);
        check("reset busy/round_done", {30'd0, busy, round_done}, 0);

        // All channels answer in full.
        run_round(5'h1F, 5'h1F, 5'h00, 5'h00);
        repeat (5) @(posedge clk80MHz);
        #1;
        check("status holds while idle", 32'(ch_ok), 32'h1F);

        // Sparse mask: disabled channels must never touch their lines.
        quiet_mask = 5'b01011;
        run_round(5'b10100, 5'b10100, 5'h00, 5'h00);
        check("disabled channels stay quiet", quiet_viol, 0);
        quiet_mask = '0;

        // Foreign rx_valid while channel 0 is served.
        noise_ch = 1;
        run_round(5'b00011, 5'b00011, 5'h00, 5'h00);
        noise_ch = -1;

        // Channel 3 stops after 12 bytes.
        nbytes[3] = 12;
`ifdef POLL_RETRY_EN
        run_round(5'h1F, 5'b10111, 5'b01000, 5'b01000);
`else
        run_round(5'h1F, 5'b10111, 5'b01000, 5'b00000);
`endif
        nbytes[3] = BYTES;

        // Reset during channel 2 RX; a poll_start while busy is also ignored.
        nbytes[2] = 0;
        push_exp(1'b0, 10'd1);
        push_exp(1'b0, 10'd2);
        push_exp(1'b0, 10'd4);
        start_round(5'h1F);
        repeat (5) @(posedge clk80MHz);
        #1;
        poll_start = 1'b1;
        ch_en      = 5'b00001;
        @(posedge clk80MHz); #1;
        poll_start = 1'b0;
        n = 0;
        while (!(rx_sel == 3'd2 && !UART_dRX[2]) && n < 2000) begin
            @(posedge clk80MHz); #1;
            n++;
        end
        check("reached channel 2 RX", 32'(rx_sel == 3'd2 && !UART_dRX[2]), 1);
        repeat (50) @(posedge clk80MHz);
        #2;
        rst = 1'b0;
        #1;
        check("async reset UART_dRX", 32'(UART_dRX), 32'h1F);
        check("async reset busy", 32'(busy), 0);
        check("async reset UART_dTX/tx_start", {22'd0, UART_dTX, tx_start}, 0);
        check("launches before reset", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(posedge clk80MHz);
        #1;
        rst = 1'b1;
        nbytes[2] = BYTES;
        run_round(5'h1F, 5'h1F, 5'h00, 5'h00);

`ifdef POLL_RETRY_EN
        // Channel 1 silent on the first attempt, answers the retry.
        silent_first[1] = 1'b1;
        run_round(5'h1F, 5'h1F, 5'h00, 5'b00010);
        silent_first[1] = 1'b0;
`endif

        // Empty mask: round completes with no line activity.
        quiet_mask = 5'h1F;
        run_round(5'h00, 5'h00, 5'h00, 5'h00);
        check("empty mask stays quiet", quiet_viol, 0);
        quiet_mask = '0;

        check("at most one active channel", multi_viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
